// File: rtl/key_event_encoder.sv
// Push-button front end: synchronises and debounces 12 raw buttons, then turns
// each debounced press into a one-cycle key code, serialising coincident presses.
module key_event_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keypad_in,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [11:0] key_down,
  output logic [11:0] pending,
  output logic        dropped
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [11:0]      sync1_q, sync2_q;
  logic [11:0]      key_down_q, key_down_d;
  logic [11:0]      pending_q, pending_d;
  logic [11:0]      press, clr;
  logic [CNT_W-1:0] cnt_q [12];
  logic [CNT_W-1:0] cnt_d [12];
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             dropped_q, dropped_d;

  // A counter only runs while the synchronised input disagrees with the
  // debounced level, so it is cleared by agreement or by the toggle itself.
  always_comb begin
    key_down_d = key_down_q;
    press      = '0;
    for (int i = 0; i < 12; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != key_down_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          key_down_d[i] = ~key_down_q[i];
          press[i]      = ~key_down_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // key_valid is a pure qualifier of key_code: high exactly when a code is
  // presented, for one cycle per press, with no back-pressure from consumers.
  always_comb begin
    clr        = pending_q & (~pending_q + 12'd1);
    key_code_d = '0;
    for (int i = 11; i >= 0; i--) begin
      if (pending_q[i]) key_code_d = 4'(i + 1);
    end
    key_valid_d = |pending_q;
    // A press on the bit being emitted this edge re-queues it as a new event.
    pending_d   = (pending_q & ~clr) | press;
    dropped_d   = |(press & pending_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_down_q  <= '0;
      pending_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
      for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q     <= keypad_in;
      sync2_q     <= sync1_q;
      key_down_q  <= key_down_d;
      pending_q   <= pending_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      dropped_q   <= dropped_d;
      for (int i = 0; i < 12; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign pending   = pending_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder (DEB_CYCLES=4); edge numbers in the
// comments count clk rising edges after the stimulus is applied.
module tb_key_event_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] keypad_in = '0;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [11:0] key_down;
  logic [11:0] pending;
  logic        dropped;

  int n_checks = 0;
  int n_pass   = 0;
  int drop_cnt = 0;
  int d0;
  logic [3:0] exp_q[$];

  key_event_encoder #(.DEB_CYCLES(4), .CNT_W(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .keypad_in (keypad_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .pending   (pending),
    .dropped   (dropped)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    keypad_in = '0;
    step(2);
    chk("rst_key_down",  32'(key_down),  32'h0);
    chk("rst_pending",   32'(pending),   32'h0);
    chk("rst_key_code",  32'(key_code),  32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_dropped",   32'(dropped),   32'h0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: every emitted code must match the next expected code
  always @(posedge clk) begin
    #1;
    chk("valid_matches_code", 32'(key_valid), 32'(key_code != 4'd0));
    if (dropped) drop_cnt++;
    if (key_valid) begin
      if (exp_q.size() == 0) chk("unexpected_code", 32'(key_code), 32'd0);
      else chk("code_order", 32'(key_code), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // hold b3: key_down at edge 6, code 3 at edge 7 only
    do_reset();
    d0 = drop_cnt;
    exp_q.push_back(4'd3);
    keypad_in = 12'h004;
    step(5);
    chk("t1_kd_e5", 32'(key_down), 32'h000);
    step(1);
    chk("t1_kd_e6",   32'(key_down), 32'h004);
    chk("t1_pend_e6", 32'(pending),  32'h004);
    chk("t1_code_e6", 32'(key_code), 32'h0);
    step(1);
    chk("t1_code_e7",  32'(key_code),  32'd3);
    chk("t1_valid_e7", 32'(key_valid), 32'd1);
    chk("t1_pend_e7",  32'(pending),   32'h000);
    step(1);
    chk("t1_code_e8",  32'(key_code),  32'd0);
    chk("t1_valid_e8", 32'(key_valid), 32'd0);
    step(10);
    chk("t1_code_held", 32'(key_code), 32'd0);
    chk("t1_kd_held",   32'(key_down), 32'h004);
    drain();

    // b5 glitches of 3 cycles never reach the debounced level
    do_reset();
    keypad_in = 12'h010; step(3);
    keypad_in = 12'h000; step(1);
    keypad_in = 12'h010; step(3);
    keypad_in = 12'h000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("t2_kd5_low", 32'(key_down[4]), 32'd0);
      chk("t2_code0",   32'(key_code),    32'd0);
    end

    // b2 + b9 together: code 2 then 9
    do_reset();
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd9);
    keypad_in = 12'h102;
    step(6);
    chk("t3_pend_e6", 32'(pending),  32'h102);
    chk("t3_kd_e6",   32'(key_down), 32'h102);
    step(1);
    chk("t3_code_e7", 32'(key_code), 32'd2);
    chk("t3_pend_e7", 32'(pending),  32'h100);
    step(1);
    chk("t3_code_e8", 32'(key_code), 32'd9);
    chk("t3_pend_e8", 32'(pending),  32'h000);
    step(1);
    chk("t3_code_e9", 32'(key_code), 32'd0);
    drain();

    // b1 press, release 10, press again: two events
    do_reset();
    d0 = drop_cnt;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd1);
    keypad_in = 12'h001; step(10);
    keypad_in = 12'h000; step(10);
    chk("t4_released", 32'(key_down), 32'h000);
    keypad_in = 12'h001; step(10);
    keypad_in = 12'h000;
    drain();
    chk("t4_no_drop", 32'(drop_cnt - d0), 32'd0);

    // b1 + b12 held, b1 re-pressed: 1, 12, 1
    do_reset();
    d0 = drop_cnt;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd12);
    exp_q.push_back(4'd1);
    keypad_in = 12'h801;
    step(7);
    chk("t5_code_e7", 32'(key_code), 32'd1);
    step(1);
    chk("t5_code_e8", 32'(key_code), 32'd12);
    keypad_in = 12'h800; step(10);
    keypad_in = 12'h801; step(10);
    drain();
    chk("t5_no_drop", 32'(drop_cnt - d0), 32'd0);

    // all keys; b12 re-press lands on the edge its pending bit is emitted
    do_reset();
    d0 = drop_cnt;
    for (int k = 1; k <= 12; k++) exp_q.push_back(4'(k));
    exp_q.push_back(4'd12);
    keypad_in = 12'hFFF; step(6);
    keypad_in = 12'h7FF; step(6);
    chk("t6_kd12_low", 32'(key_down), 32'h7FF);
    keypad_in = 12'hFFF; step(6);
    chk("t6_pend_e18", 32'(pending),  32'h800);
    chk("t6_code_e18", 32'(key_code), 32'd12);
    chk("t6_drop_e18", 32'(dropped),  32'd0);
    step(1);
    chk("t6_code_e19", 32'(key_code), 32'd12);
    chk("t6_pend_e19", 32'(pending),  32'h000);
    drain();
    chk("t6_no_drop", 32'(drop_cnt - d0), 32'd0);

    // b12 re-press one edge earlier, while still queued: dropped pulse
    do_reset();
    d0 = drop_cnt;
    for (int k = 1; k <= 12; k++) exp_q.push_back(4'(k));
    keypad_in = 12'hFFF; step(6);
    keypad_in = 12'h7FF; step(5);
    keypad_in = 12'hFFF; step(6);
    chk("t7_drop_e17", 32'(dropped),  32'd1);
    chk("t7_pend_e17", 32'(pending),  32'h800);
    chk("t7_code_e17", 32'(key_code), 32'd11);
    step(1);
    chk("t7_drop_e18", 32'(dropped),  32'd0);
    chk("t7_code_e18", 32'(key_code), 32'd12);
    step(1);
    chk("t7_code_e19", 32'(key_code), 32'd0);
    drain();
    chk("t7_one_drop", 32'(drop_cnt - d0), 32'd1);

    // b7 held through a 1-cycle reset is re-detected 7 edges later
    do_reset();
    exp_q.push_back(4'd7);
    keypad_in = 12'h040;
    step(6);
    chk("t8_kd_e6", 32'(key_down), 32'h040);
    step(5);
    rst = 1'b1;
    step(1);
    chk("t8_code_rst", 32'(key_code),  32'd0);
    chk("t8_pend_rst", 32'(pending),   32'h000);
    chk("t8_kd_rst",   32'(key_down),  32'h000);
    chk("t8_vld_rst",  32'(key_valid), 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'd7);
    step(6);
    chk("t8_kd_r6",   32'(key_down), 32'h040);
    chk("t8_code_r6", 32'(key_code), 32'd0);
    step(1);
    chk("t8_code_r7", 32'(key_code), 32'd7);
    drain();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
